gbdt_dma_tx: RTL and testbench

DMA-side feature-stream transmitter: the source end of the `DMA_data`/`DMA_valid` interface consumed by the GBDT accelerator. It buffers feature words pushed by the host-side fabric into a FIFO. When a full sample is buffered, it emits that sample as one back-to-back burst of `DMA_valid` beats. It then holds off until the accelerator's `done` rises before sending the next sample. The block sits between the SoC data mover and the accelerator's DMA input port.

---
 rtl/gbdt_dma_tx_if.sv | 28 ++
 rtl/gbdt_dma_tx.sv | 89 ++++++++
 tb/tb_gbdt_dma_tx.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gbdt_dma_tx_if.sv
// gbdt_dma_tx_if: host push port, burst controls and DMA beat stream of the GBDT feature transmitter
interface gbdt_dma_tx_if #(
    parameter int DMA_RATE   = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
    logic [DMA_RATE-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [CNT_W-1:0]    beats_per_sample;
    logic                tx_enable;
    logic                done;
    logic [DMA_RATE-1:0] DMA_data;
    logic                DMA_valid;
    logic                busy;
    logic                cfg_err;
    logic [15:0]         samples_sent;
    logic [CNT_W-1:0]    fifo_count;

    modport slave (
        input  in_data, in_valid, beats_per_sample, tx_enable, done,
        output in_ready, DMA_data, DMA_valid, busy, cfg_err, samples_sent, fifo_count
    );
    modport master (
        output in_data, in_valid, beats_per_sample, tx_enable, done,
        input  in_ready, DMA_data, DMA_valid, busy, cfg_err, samples_sent, fifo_count
    );
endinterface

// File: rtl/gbdt_dma_tx.sv
// gbdt_dma_tx: buffers host feature words and emits one sample per burst, interlocked on the accelerator's done edge
module gbdt_dma_tx #(
    parameter int DMA_RATE   = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input logic          gbdt_clk,
    input logic          gbdt_rst,
    gbdt_dma_tx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, BURST, WAIT_DONE} state_t;
    state_t              state_q, state_d;
    logic [DMA_RATE-1:0] mem_q [FIFO_DEPTH];
    logic [DMA_RATE-1:0] data_q, data_d;
    logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, count, n_eff;
    logic [15:0]         sent_q, sent_d;
    logic                valid_q, valid_d, cfg_err_q, cfg_err_d, done_q;
    logic                push, pop, start, illegal;

    assign count   = CNT_W'(wr_q - rd_q);
    assign push    = bus.in_valid && bus.in_ready;
    assign illegal = bus.beats_per_sample > CNT_W'(FIFO_DEPTH);
    assign n_eff   = (bus.beats_per_sample == '0) ? CNT_W'(1) : bus.beats_per_sample;
    assign start   = state_q == IDLE && bus.tx_enable && !cfg_err_q && !illegal && count >= n_eff;
    // The head word leaves on the start edge itself; cnt_q then holds the beats still to go
    assign pop     = start || (state_q == BURST && cnt_q != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sent_d    = sent_q;
        cfg_err_d = cfg_err_q || (state_q == IDLE && illegal);
        case (state_q)
            IDLE: if (start) begin
                state_d = BURST;
                cnt_d   = n_eff - CNT_W'(1);
            end
            BURST: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                   else state_d = WAIT_DONE;
            WAIT_DONE: if (bus.done && !done_q) begin
                state_d = IDLE;
                sent_d  = sent_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
        wr_d    = wr_q + {{AW{1'b0}}, push};
        rd_d    = rd_q + {{AW{1'b0}}, pop};
        valid_d = pop;
        data_d  = pop ? mem_q[rd_q[AW-1:0]] : '0;
    end

    always_ff @(posedge gbdt_clk) begin
        if (gbdt_rst) begin
            state_q   <= IDLE;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            sent_q    <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            sent_q    <= sent_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            cfg_err_q <= cfg_err_d;
            done_q    <= bus.done;
        end
    end

    always_ff @(posedge gbdt_clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= bus.in_data;
    end

    assign bus.in_ready     = count != CNT_W'(FIFO_DEPTH);
    assign bus.DMA_data     = data_q;
    assign bus.DMA_valid    = valid_q;
    assign bus.busy         = state_q != IDLE;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.samples_sent = sent_q;
    assign bus.fifo_count   = count;
endmodule

// File: tb/tb_gbdt_dma_tx.sv
// tb_gbdt_dma_tx: randomized scoreboard bench; accepted words queue up at push time and every beat run is checked by an independent monitor
module tb_gbdt_dma_tx;
    localparam int DW = 32, D = 16, CW = $clog2(D) + 1;
    logic gbdt_clk = 1'b0;
    logic gbdt_rst = 1'b1;
    gbdt_dma_tx_if #(.DMA_RATE(DW), .FIFO_DEPTH(D), .CNT_W(CW)) bus ();
    gbdt_dma_tx #(.DMA_RATE(DW), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
        .gbdt_clk(gbdt_clk), .gbdt_rst(gbdt_rst), .bus(bus)
    );
    always #5 gbdt_clk = ~gbdt_clk;

    logic [DW-1:0] exp_q[$];
    int            len_q[$];
    int            n_cmp = 0, n_bad = 0;
    int            runs_started = 0, runs_ended = 0, runs_acked = 0, nrun = 0, runlen = 0;
    int            pushed_e, done_e, n, s;
    logic [DW-1:0] w;
    logic [15:0]   exp_sent = '0;
    bit            mon_on = 0, in_run = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    task automatic step(input int k = 1);
        repeat (k) @(posedge gbdt_clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v, input bit keep);
        if (keep) exp_q.push_back(v);
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_runs(input int target);
        int c = 0;
        while (runs_ended < target && c < 400) begin
            step();
            c++;
        end
        if (runs_ended < target) bad("run_timeout");
    endtask

    task automatic do_done(input int hold);
        chk("busy_before_done", bus.busy, 1);
        bus.done = 1'b1;
        runs_acked++;
        exp_sent++;
        step();
        @(negedge gbdt_clk);
        chk("samples_sent", bus.samples_sent, exp_sent);
        chk("busy_after_done", bus.busy, 0);
        step(hold);
        bus.done = 1'b0;
        step();
    endtask

    // Monitor: each beat must be the oldest outstanding accepted word; each run must match the queued sample length
    always @(negedge gbdt_clk) begin
        if (mon_on) begin
            if (bus.DMA_valid) begin
                if (!in_run) begin
                    chk("interlock", runs_started, runs_acked);
                    runs_started++;
                    in_run = 1;
                    runlen = 0;
                end
                runlen++;
                if (exp_q.size() == 0) bad("unexpected_beat");
                else chk("beat_data", bus.DMA_data, exp_q.pop_front());
            end else begin
                chk("idle_data_zero", bus.DMA_data, 0);
                if (in_run) begin
                    in_run = 0;
                    runs_ended++;
                    if (len_q.size() == 0) bad("unexpected_run");
                    else chk("run_len", runlen, len_q.pop_front());
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.beats_per_sample = '0;
        bus.tx_enable = 1'b0;
        bus.done = 1'b0;
        step(3);
        gbdt_rst = 1'b0;
        mon_on = 1;
        @(negedge gbdt_clk);
        chk("rst_valid", bus.DMA_valid, 0);
        chk("rst_data", bus.DMA_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        chk("rst_sent", bus.samples_sent, 0);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // single sample with start-latency check
        bus.beats_per_sample = 4;
        for (int i = 0; i < 4; i++) push(32'hA0 + i, 1);
        @(negedge gbdt_clk);
        chk("single_count", bus.fifo_count, 4);
        chk("single_idle", bus.busy, 0);
        step();
        bus.tx_enable = 1'b1;
        len_q.push_back(4);
        @(negedge gbdt_clk);
        chk("single_no_beat_yet", bus.DMA_valid, 0);
        @(negedge gbdt_clk);
        chk("single_first_beat", bus.DMA_valid, 1);
        chk("single_busy", bus.busy, 1);
        nrun++;
        wait_runs(nrun);
        step(3);
        chk("single_busy_hold", bus.busy, 1);
        do_done(1);
        bus.tx_enable = 1'b0;

        // full FIFO then a 16-beat sample
        bus.beats_per_sample = 16;
        for (int i = 0; i < 16; i++) push($urandom, 1);
        @(negedge gbdt_clk);
        chk("full_count", bus.fifo_count, 16);
        chk("full_in_ready", bus.in_ready, 0);
        push(32'hDEADBEEF, 0);
        @(negedge gbdt_clk);
        chk("full_reject", bus.fifo_count, 16);
        step();
        bus.tx_enable = 1'b1;
        len_q.push_back(16);
        @(negedge gbdt_clk);
        @(negedge gbdt_clk);
        chk("full_first_pop_count", bus.fifo_count, 15);
        chk("full_ready_back", bus.in_ready, 1);
        nrun++;
        wait_runs(nrun);
        do_done(2);
        bus.tx_enable = 1'b0;

        // concurrent push/pop and done held high across the next sample
        bus.beats_per_sample = 8;
        for (int i = 0; i < 8; i++) push($urandom, 1);
        @(negedge gbdt_clk);
        chk("cc_fill", bus.fifo_count, 8);
        step();
        bus.tx_enable = 1'b1;
        len_q.push_back(8);
        len_q.push_back(8);
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            exp_q.push_back(w);
            bus.in_data = w;
            bus.in_valid = 1'b1;
            @(negedge gbdt_clk);
            chk("cc_count", bus.fifo_count, 8);
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge gbdt_clk);
        chk("cc_count_end", bus.fifo_count, 8);
        nrun++;
        wait_runs(nrun);
        step(5);
        chk("cc_wait_busy", bus.busy, 1);
        chk("cc_no_early_pop", bus.fifo_count, 8);
        bus.done = 1'b1;
        runs_acked++;
        exp_sent++;
        step();
        @(negedge gbdt_clk);
        chk("cc_sent", bus.samples_sent, exp_sent);
        nrun++;
        wait_runs(nrun);
        step(4);
        chk("cc_held_done_busy", bus.busy, 1);
        chk("cc_held_done_sent", bus.samples_sent, exp_sent);
        bus.done = 1'b0;
        step();
        do_done(1);
        bus.tx_enable = 1'b0;

        // illegal beat count is sticky until reset
        bus.beats_per_sample = 17;
        for (int i = 0; i < 16; i++) push($urandom, 0);
        bus.tx_enable = 1'b1;
        step(4);
        @(negedge gbdt_clk);
        chk("cfg_err_set", bus.cfg_err, 1);
        chk("cfg_no_start", bus.busy, 0);
        chk("cfg_count", bus.fifo_count, 16);
        bus.beats_per_sample = 4;
        step(3);
        chk("cfg_err_sticky", bus.cfg_err, 1);
        chk("cfg_still_idle", bus.busy, 0);
        bus.tx_enable = 1'b0;
        gbdt_rst = 1'b1;
        step();
        gbdt_rst = 1'b0;
        exp_sent = '0;
        @(negedge gbdt_clk);
        chk("cfg_err_cleared", bus.cfg_err, 0);
        chk("cfg_flushed", bus.fifo_count, 0);
        chk("cfg_sent_reset", bus.samples_sent, 0);
        bus.beats_per_sample = 0;
        bus.tx_enable = 1'b1;
        len_q.push_back(1);
        push($urandom, 1);
        nrun++;
        wait_runs(nrun);
        do_done(1);
        bus.tx_enable = 1'b0;

        // reset on the second of four beats
        bus.beats_per_sample = 4;
        push($urandom, 1);
        push($urandom, 1);
        push($urandom, 0);
        push($urandom, 0);
        len_q.push_back(2);
        step();
        bus.tx_enable = 1'b1;
        repeat (3) @(negedge gbdt_clk);
        chk("mid_second_beat", bus.DMA_valid, 1);
        gbdt_rst = 1'b1;
        runs_acked++;
        nrun++;
        @(negedge gbdt_clk);
        chk("mid_rst_valid", bus.DMA_valid, 0);
        chk("mid_rst_count", bus.fifo_count, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_sent", bus.samples_sent, 0);
        gbdt_rst = 1'b0;
        bus.tx_enable = 1'b0;
        exp_sent = '0;
        step();

        // randomized epochs: pointers wrap many times while order is checked beat by beat
        for (int e = 0; e < 25; e++) begin
            n = $urandom_range(1, 8);
            s = $urandom_range(1, 3);
            pushed_e = 0;
            done_e = 0;
            bus.beats_per_sample = CW'(n);
            bus.tx_enable = 1'b1;
            for (int k = 0; k < s; k++) len_q.push_back(n);
            fork
                begin
                    for (int i = 0; i < n * s; i++) begin
                        while (pushed_e - done_e * n >= D) step();
                        push($urandom, 1);
                        pushed_e++;
                        step($urandom_range(0, 2));
                    end
                end
                begin
                    for (int k = 0; k < s; k++) begin
                        nrun++;
                        wait_runs(nrun);
                        step($urandom_range(0, 3));
                        do_done($urandom_range(1, 3));
                        done_e++;
                    end
                end
            join
            bus.tx_enable = 1'b0;
            @(negedge gbdt_clk);
            chk("epoch_drained", bus.fifo_count, 0);
        end

        // samples_sent wrap
        force dut.sent_q = 16'hFFFF;
        step();
        release dut.sent_q;
        @(negedge gbdt_clk);
        chk("wrap_preload", bus.samples_sent, 16'hFFFF);
        exp_sent = 16'hFFFF;
        bus.beats_per_sample = 1;
        bus.tx_enable = 1'b1;
        len_q.push_back(1);
        push($urandom, 1);
        nrun++;
        wait_runs(nrun);
        do_done(1);
        chk("wrap_zero", bus.samples_sent, 0);
        bus.tx_enable = 1'b0;

        step(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("runs_all_seen", len_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
